uart_seq_checker: RTL and testbench
===================================

Name: uart_seq_checker

Overview:
Synthesizable, parametrised UART receive-and-check block: deserialises 8N1-style frames from a serial line and compares each received word against an expected arithmetic sequence. Places the self-checking load/output test logic inside the design, so the same check runs in simulation and on the board with pass/fail on LEDs. Sits on the CPU's uart_tx_line; adds mid-bit sampling, stop-bit checking, configurable sequence and sticky error reporting.

Parameters:
DATA_WIDTH, 8, data bits per frame, LSB first
CLKS_PER_BIT, 2, clk cycles per serial bit; legal values are >= 2
START_VALUE, 0, first expected word
STEP, 1, increment between expected words, modulo 2^DATA_WIDTH
EXPECT_COUNT, 7, matching frames required for pass; legal values are >= 1
CNT_WIDTH, 8, width of frame_count

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
serial_in  in  1  UART line, idle high
enable  in  1  when low, the block stays in IDLE and ignores the line
data_valid  out  1  one-cycle pulse when a frame completes with a valid stop bit
last_data  out  DATA_WIDTH  last received word
expected  out  DATA_WIDTH  word the next frame must match
frame_count  out  CNT_WIDTH  count of matching frames
done  out  1  sticky; test finished
pass  out  1  sticky; EXPECT_COUNT frames matched
fail  out  1  sticky; mismatch or framing error
error_code  out  2  0 none, 1 data mismatch, 2 framing error

Behaviour:
- Reset (async, active-high): state=IDLE, all outputs 0 except expected=START_VALUE, all counters 0. Reset mid-frame abandons the frame with no error.
- Sampling: serial_in feeds a 2-flop synchroniser (sync_in), which adds 2 cycles of latency. Bit counter bc counts 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2, rounded down.
- IDLE: if enable and sync_in==0, go to START with bc=0.
- START: after HALF cycles, sample sync_in. If it is 1, treat it as a glitch: return to IDLE with no error. If it is 0, go to DATA with bc=0 and bit index=0.
- DATA: every CLKS_PER_BIT cycles, sample sync_in into shift[bit index], LSB first. After bit DATA_WIDTH-1, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample. If the sample is 0, set fail=1, error_code=2, done=1 and go to DONE. If it is 1, go to CHECK.
- CHECK (one cycle): last_data<=shift and data_valid=1. Then:
  - If shift==expected: expected<=expected+STEP (wraps modulo 2^DATA_WIDTH) and frame_count++. If the new frame_count equals EXPECT_COUNT: pass=1, done=1, go to DONE. Otherwise go to IDLE.
  - If shift!=expected: fail=1, error_code=1, done=1, go to DONE. expected is held at the mismatching value for debug.
- DONE: absorbing state; serial_in is ignored; only reset leaves it. pass and fail are never both 1.
- enable deasserted mid-frame: the current frame completes; no new start is accepted.
- frame_count saturates at its maximum value; this is not an error.
- Latency: data_valid asserts 2 + HALF + (DATA_WIDTH+1)*CLKS_PER_BIT + 1 cycles after the start-bit falling edge at serial_in.
- A start bit directly after the stop bit is accepted: IDLE re-arms the cycle after CHECK.

Test Plan:
- Defaults, frames 0..6 back-to-back at 2 clk/bit -> data_valid pulses 7 times; after the 7th frame pass=1, done=1, frame_count=7, error_code=0.
- Frames 0,1,5 -> after the 3rd frame fail=1, error_code=1, last_data=5, expected=2, frame_count=2; a later frame 2 leaves all outputs unchanged.
- Frame 0 with stop bit driven 0 -> fail=1, error_code=2, data_valid never pulses, frame_count=0.
- serial_in low for 1 clk cycle with CLKS_PER_BIT=4 -> no state change, no error; a following valid frame 0 is received and frame_count=1.
- rst pulsed during bit 4 of frame 2, then frames 0..6 sent -> reset values at the async edge, then pass=1 after 7 frames.
- DATA_WIDTH=8, START_VALUE=250, STEP=3, EXPECT_COUNT=4, frames 250,253,0,3 -> wrap is handled and pass=1; enable=0 during a frame -> the frame is ignored and frame_count is unchanged.

Source files
------------

// File: rtl/uart_seq_checker.sv
// -----------------------------------------------------------------------------
// uart_seq_checker
//
// Receives UART frames (start bit, DATA_WIDTH data bits LSB first, one stop
// bit) and checks each received word against an arithmetic sequence that
// starts at START_VALUE and advances by STEP (modulo 2^DATA_WIDTH). Once
// EXPECT_COUNT words have matched, pass is raised. A data mismatch or a bad
// stop bit raises fail instead. Both are sticky until reset.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   serial_in    UART line, idle high
//   enable       when low, no new frame is started
//   data_valid   one-cycle pulse per frame that has a valid stop bit
//   last_data    most recently received word
//   expected     word the next frame must match
//   frame_count  number of matching frames (saturating)
//   done         sticky, the test has finished
//   pass         sticky, EXPECT_COUNT frames matched
//   fail         sticky, data mismatch or framing error
//   error_code   0 none, 1 data mismatch, 2 framing error
// -----------------------------------------------------------------------------
module uart_seq_checker #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 2,
  parameter int START_VALUE  = 0,
  parameter int STEP         = 1,
  parameter int EXPECT_COUNT = 7,
  parameter int CNT_WIDTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  serial_in,
  input  logic                  enable,
  output logic                  data_valid,
  output logic [DATA_WIDTH-1:0] last_data,
  output logic [DATA_WIDTH-1:0] expected,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic                  done,
  output logic                  pass,
  output logic                  fail,
  output logic [1:0]            error_code
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int BC_W = $clog2(CLKS_PER_BIT);
  localparam int BI_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BC_W-1:0]       BC_HALF  = BC_W'(HALF - 1);
  localparam logic [BC_W-1:0]       BC_LAST  = BC_W'(CLKS_PER_BIT - 1);
  localparam logic [BI_W-1:0]       BI_LAST  = BI_W'(DATA_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] START_W  = DATA_WIDTH'(START_VALUE);
  localparam logic [DATA_WIDTH-1:0] STEP_W   = DATA_WIDTH'(STEP);
  localparam logic [CNT_WIDTH-1:0]  EXP_CNT  = CNT_WIDTH'(EXPECT_COUNT);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_DATA  = 2'd1;
  localparam logic [1:0] ERR_FRAME = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_CHECK,
    S_DONE
  } state_t;

  state_t                 state_q;
  logic                   meta_q;
  logic                   sync_q;
  logic [BC_W-1:0]        bc_q;
  logic [BI_W-1:0]        bit_idx_q;
  logic [DATA_WIDTH-1:0]  shift_q;
  logic                   data_valid_q;
  logic [DATA_WIDTH-1:0]  last_data_q;
  logic [DATA_WIDTH-1:0]  expected_q;
  logic [CNT_WIDTH-1:0]   frame_count_q;
  logic                   done_q;
  logic                   pass_q;
  logic                   fail_q;
  logic [1:0]             error_code_q;

  logic [DATA_WIDTH-1:0]  expected_d;
  logic [CNT_WIDTH-1:0]   frame_count_d;
  logic                   start_seen;

  // Two-flop synchroniser for the asynchronous serial line.
  // NOTE: the synchroniser resets to 1 (line idle) so leaving reset never
  // looks like a falling start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= serial_in;
      sync_q <= meta_q;
    end
  end

  // NOTE: every signal driven here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    expected_d    = expected_q + STEP_W;
    frame_count_d = (frame_count_q == '1) ? frame_count_q
                                          : frame_count_q + 1'b1;
    start_seen    = enable && !sync_q;
  end

  // Receiver and checker FSM with registered outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // branch sees the pre-edge values of all registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      bc_q          <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      data_valid_q  <= 1'b0;
      last_data_q   <= '0;
      expected_q    <= START_W;
      frame_count_q <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
      error_code_q  <= ERR_NONE;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_seen) begin
            state_q <= S_START;
            bc_q    <= '0;
          end
        end

        // Re-check the line half a bit in; a high sample was only a glitch.
        S_START: begin
          if (bc_q == BC_HALF) begin
            bc_q <= '0;
            if (sync_q) begin
              state_q <= S_IDLE;
            end else begin
              state_q   <= S_DATA;
              bit_idx_q <= '0;
            end
          end else begin
            bc_q <= bc_q + 1'b1;
          end
        end

        S_DATA: begin
          if (bc_q == BC_LAST) begin
            bc_q               <= '0;
            shift_q[bit_idx_q] <= sync_q;
            if (bit_idx_q == BI_LAST) begin
              state_q <= S_STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            bc_q <= bc_q + 1'b1;
          end
        end

        S_STOP: begin
          if (bc_q == BC_LAST) begin
            bc_q <= '0;
            if (sync_q) begin
              state_q <= S_CHECK;
            end else begin
              fail_q       <= 1'b1;
              error_code_q <= ERR_FRAME;
              done_q       <= 1'b1;
              state_q      <= S_DONE;
            end
          end else begin
            bc_q <= bc_q + 1'b1;
          end
        end

        S_CHECK: begin
          data_valid_q <= 1'b1;
          last_data_q  <= shift_q;
          if (shift_q == expected_q) begin
            expected_q    <= expected_d;
            frame_count_q <= frame_count_d;
            if (frame_count_d == EXP_CNT) begin
              pass_q  <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else if (start_seen) begin
              // A start bit that follows the stop bit immediately is already
              // on the synchronised line here; catching it now keeps the
              // mid-bit sample point aligned even at 2 clocks per bit.
              state_q <= S_START;
              bc_q    <= '0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            // expected is held at the mismatching value for debug.
            fail_q       <= 1'b1;
            error_code_q <= ERR_DATA;
            done_q       <= 1'b1;
            state_q      <= S_DONE;
          end
        end

        S_DONE: begin
          // Absorbing: only reset leaves this state.
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign data_valid  = data_valid_q;
  assign last_data   = last_data_q;
  assign expected    = expected_q;
  assign frame_count = frame_count_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail        = fail_q;
  assign error_code  = error_code_q;

endmodule

// File: tb/tb_uart_seq_checker.sv
// -----------------------------------------------------------------------------
// tb_uart_seq_checker
//
// Directed testbench for uart_seq_checker. Three instances:
//   u_def   defaults (8 bits, 2 clk/bit, sequence 0,1,2.., 7 frames)
//   u_slow  4 clk/bit, used for the start-glitch scenario
//   u_wrap  START_VALUE=250, STEP=3, EXPECT_COUNT=4 (sequence wraps)
// Serial lines are driven on the falling clock edge; outputs are sampled on
// the falling edge (or 1 ns after a rising edge for the latency check).
// -----------------------------------------------------------------------------
module tb_uart_seq_checker;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic ser0 = 1'b1, ser1 = 1'b1, ser2 = 1'b1;
  logic en0  = 1'b1, en1  = 1'b1, en2  = 1'b1;

  logic       dv0, dv1, dv2;
  logic [7:0] ld0, ld1, ld2;
  logic [7:0] ex0, ex1, ex2;
  logic [7:0] fc0, fc1, fc2;
  logic       dn0, dn1, dn2;
  logic       ps0, ps1, ps2;
  logic       fl0, fl1, fl2;
  logic [1:0] ec0, ec1, ec2;

  int asserts  = 0;
  int failures = 0;

  int dv_cnt0 = 0, dv_cnt1 = 0, dv_cnt2 = 0;

  always #5 clk = ~clk;

  uart_seq_checker u_def (
    .clk(clk), .rst(rst), .serial_in(ser0), .enable(en0),
    .data_valid(dv0), .last_data(ld0), .expected(ex0), .frame_count(fc0),
    .done(dn0), .pass(ps0), .fail(fl0), .error_code(ec0)
  );

  uart_seq_checker #(.CLKS_PER_BIT(4)) u_slow (
    .clk(clk), .rst(rst), .serial_in(ser1), .enable(en1),
    .data_valid(dv1), .last_data(ld1), .expected(ex1), .frame_count(fc1),
    .done(dn1), .pass(ps1), .fail(fl1), .error_code(ec1)
  );

  uart_seq_checker #(.START_VALUE(250), .STEP(3), .EXPECT_COUNT(4)) u_wrap (
    .clk(clk), .rst(rst), .serial_in(ser2), .enable(en2),
    .data_valid(dv2), .last_data(ld2), .expected(ex2), .frame_count(fc2),
    .done(dn2), .pass(ps2), .fail(fl2), .error_code(ec2)
  );

  // Count data_valid pulses per instance (each pulse is one cycle wide).
  always @(negedge clk) begin
    if (dv0 === 1'b1) dv_cnt0 <= dv_cnt0 + 1;
    if (dv1 === 1'b1) dv_cnt1 <= dv_cnt1 + 1;
    if (dv2 === 1'b1) dv_cnt2 <= dv_cnt2 + 1;
  end

  task automatic set_line(input int d, input logic v);
    case (d)
      0:       ser0 = v;
      1:       ser1 = v;
      default: ser2 = v;
    endcase
  endtask

  // Drive the first 'slots' bit periods of a frame (10 = whole frame).
  task automatic send_frame(input int d, input logic [7:0] data,
                            input logic stop_bit, input int cpb,
                            input int slots);
    logic [9:0] bits;
    bits = {stop_bit, data, 1'b0};
    for (int i = 0; i < slots; i++) begin
      set_line(d, bits[i]);
      repeat (cpb) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    ser0 = 1'b1; ser1 = 1'b1; ser2 = 1'b1;
    en0  = 1'b1; en1  = 1'b1; en2  = 1'b1;
    rst  = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    asserts++;
    if ({dv0, dn0, ps0, fl0, ec0} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b want 000000", {dv0, dn0, ps0, fl0, ec0});
    end
    asserts++;
    if (fc0 !== 8'd0 || ld0 !== 8'd0) begin
      failures++;
      $display("FAIL reset_counts: got fc=%0d ld=%0d want 0 0", fc0, ld0);
    end
    asserts++;
    if (ex0 !== 8'd0) begin
      failures++;
      $display("FAIL reset_expected_def: got %0d want 0", ex0);
    end
    asserts++;
    if (ex2 !== 8'd250) begin
      failures++;
      $display("FAIL reset_expected_wrap: got %0d want 250", ex2);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_latency();
    int lat;
    do_reset();
    lat = -1;
    fork
      send_frame(0, 8'h00, 1'b1, 2, 10);
      begin
        for (int n = 0; n < 40; n++) begin
          @(posedge clk);
          #1;
          if (dv0 === 1'b1 && lat < 0) lat = n;
        end
      end
    join
    // 2 sync + HALF(1) + 9 bits * 2 + 1 = 22
    asserts++;
    if (lat !== 22) begin
      failures++;
      $display("FAIL latency: got %0d cycles want 22", lat);
    end
    @(negedge clk);
    asserts++;
    if (fc0 !== 8'd1 || ex0 !== 8'd1 || ld0 !== 8'd0) begin
      failures++;
      $display("FAIL latency_frame: got fc=%0d ex=%0d ld=%0d want 1 1 0", fc0, ex0, ld0);
    end
  endtask

  task automatic test_back_to_back();
    int dv_start;
    do_reset();
    dv_start = dv_cnt0;
    for (int i = 0; i < 7; i++) send_frame(0, 8'(i), 1'b1, 2, 10);
    repeat (5) @(negedge clk);
    asserts++;
    if (dv_cnt0 - dv_start !== 7) begin
      failures++;
      $display("FAIL b2b_pulses: got %0d want 7", dv_cnt0 - dv_start);
    end
    asserts++;
    if ({ps0, dn0, fl0} !== 3'b110 || ec0 !== 2'd0) begin
      failures++;
      $display("FAIL b2b_status: got pass/done/fail=%b ec=%0d want 110 0", {ps0, dn0, fl0}, ec0);
    end
    asserts++;
    if (fc0 !== 8'd7 || ld0 !== 8'd6 || ex0 !== 8'd7) begin
      failures++;
      $display("FAIL b2b_values: got fc=%0d ld=%0d ex=%0d want 7 6 7", fc0, ld0, ex0);
    end
  endtask

  task automatic test_mismatch();
    int dv_start;
    do_reset();
    dv_start = dv_cnt0;
    send_frame(0, 8'd0, 1'b1, 2, 10);
    send_frame(0, 8'd1, 1'b1, 2, 10);
    send_frame(0, 8'd5, 1'b1, 2, 10);
    repeat (5) @(negedge clk);
    asserts++;
    if ({ps0, dn0, fl0} !== 3'b011 || ec0 !== 2'd1) begin
      failures++;
      $display("FAIL mismatch_status: got pass/done/fail=%b ec=%0d want 011 1", {ps0, dn0, fl0}, ec0);
    end
    asserts++;
    if (ld0 !== 8'd5 || ex0 !== 8'd2 || fc0 !== 8'd2) begin
      failures++;
      $display("FAIL mismatch_values: got ld=%0d ex=%0d fc=%0d want 5 2 2", ld0, ex0, fc0);
    end
    // DONE is absorbing: a correct frame afterwards changes nothing.
    send_frame(0, 8'd2, 1'b1, 2, 10);
    repeat (5) @(negedge clk);
    asserts++;
    if (ld0 !== 8'd5 || ex0 !== 8'd2 || fc0 !== 8'd2 || ec0 !== 2'd1 ||
        ps0 !== 1'b0 || dv_cnt0 - dv_start !== 3) begin
      failures++;
      $display("FAIL mismatch_absorb: got ld=%0d ex=%0d fc=%0d ec=%0d pass=%b pulses=%0d want 5 2 2 1 0 3",
               ld0, ex0, fc0, ec0, ps0, dv_cnt0 - dv_start);
    end
  endtask

  task automatic test_framing();
    int dv_start;
    do_reset();
    dv_start = dv_cnt0;
    send_frame(0, 8'd0, 1'b0, 2, 10);
    ser0 = 1'b1;
    repeat (5) @(negedge clk);
    asserts++;
    if ({ps0, dn0, fl0} !== 3'b011 || ec0 !== 2'd2) begin
      failures++;
      $display("FAIL framing_status: got pass/done/fail=%b ec=%0d want 011 2", {ps0, dn0, fl0}, ec0);
    end
    asserts++;
    if (fc0 !== 8'd0 || dv_cnt0 - dv_start !== 0) begin
      failures++;
      $display("FAIL framing_count: got fc=%0d pulses=%0d want 0 0", fc0, dv_cnt0 - dv_start);
    end
  endtask

  task automatic test_glitch();
    int dv_start;
    do_reset();
    dv_start = dv_cnt1;
    ser1 = 1'b0;
    @(negedge clk);
    ser1 = 1'b1;
    repeat (12) @(negedge clk);
    asserts++;
    if ({dn1, fl1} !== 2'b00 || ec1 !== 2'd0 || fc1 !== 8'd0 || dv_cnt1 - dv_start !== 0) begin
      failures++;
      $display("FAIL glitch_ignored: got done/fail=%b ec=%0d fc=%0d pulses=%0d want 00 0 0 0",
               {dn1, fl1}, ec1, fc1, dv_cnt1 - dv_start);
    end
    send_frame(1, 8'd0, 1'b1, 4, 10);
    repeat (6) @(negedge clk);
    asserts++;
    if (fc1 !== 8'd1 || ex1 !== 8'd1 || ld1 !== 8'd0 || dv_cnt1 - dv_start !== 1 || fl1 !== 1'b0) begin
      failures++;
      $display("FAIL glitch_then_frame: got fc=%0d ex=%0d ld=%0d pulses=%0d fail=%b want 1 1 0 1 0",
               fc1, ex1, ld1, dv_cnt1 - dv_start, fl1);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_reset();
    send_frame(0, 8'd0, 1'b1, 2, 10);
    send_frame(0, 8'd1, 1'b1, 2, 10);
    // Frame 2: start + bits 0..3, then one cycle into bit 4.
    send_frame(0, 8'd2, 1'b1, 2, 5);
    ser0 = 1'b0;
    @(negedge clk);
    asserts++;
    if (fc0 !== 8'd2 || ld0 !== 8'd1) begin
      failures++;
      $display("FAIL midreset_before: got fc=%0d ld=%0d want 2 1", fc0, ld0);
    end
    #2 rst = 1'b1;
    #1;
    asserts++;
    if (fc0 !== 8'd0 || ex0 !== 8'd0 || ld0 !== 8'd0 || {dn0, fl0, ps0} !== 3'b000) begin
      failures++;
      $display("FAIL midreset_async: got fc=%0d ex=%0d ld=%0d done/fail/pass=%b want 0 0 0 000",
               fc0, ex0, ld0, {dn0, fl0, ps0});
    end
    ser0 = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 7; i++) send_frame(0, 8'(i), 1'b1, 2, 10);
    repeat (5) @(negedge clk);
    asserts++;
    if (ps0 !== 1'b1 || fl0 !== 1'b0 || fc0 !== 8'd7) begin
      failures++;
      $display("FAIL midreset_after: got pass=%b fail=%b fc=%0d want 1 0 7", ps0, fl0, fc0);
    end
  endtask

  task automatic test_wrap_enable();
    int dv_start;
    do_reset();
    dv_start = dv_cnt2;
    send_frame(2, 8'd250, 1'b1, 2, 10);
    send_frame(2, 8'd253, 1'b1, 2, 10);
    repeat (5) @(negedge clk);
    en2 = 1'b0;
    send_frame(2, 8'd99, 1'b1, 2, 10);
    repeat (5) @(negedge clk);
    asserts++;
    if (fc2 !== 8'd2 || ld2 !== 8'd253 || ex2 !== 8'd0 || dv_cnt2 - dv_start !== 2 || fl2 !== 1'b0) begin
      failures++;
      $display("FAIL wrap_disabled: got fc=%0d ld=%0d ex=%0d pulses=%0d fail=%b want 2 253 0 2 0",
               fc2, ld2, ex2, dv_cnt2 - dv_start, fl2);
    end
    en2 = 1'b1;
    repeat (2) @(negedge clk);
    send_frame(2, 8'd0, 1'b1, 2, 10);
    send_frame(2, 8'd3, 1'b1, 2, 10);
    repeat (5) @(negedge clk);
    asserts++;
    if ({ps2, dn2, fl2} !== 3'b110 || ec2 !== 2'd0) begin
      failures++;
      $display("FAIL wrap_status: got pass/done/fail=%b ec=%0d want 110 0", {ps2, dn2, fl2}, ec2);
    end
    asserts++;
    if (fc2 !== 8'd4 || ex2 !== 8'd6 || ld2 !== 8'd3) begin
      failures++;
      $display("FAIL wrap_values: got fc=%0d ex=%0d ld=%0d want 4 6 3", fc2, ex2, ld2);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_back_to_back();
    test_mismatch();
    test_framing();
    test_glitch();
    test_reset_mid_frame();
    test_wrap_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
